flow_feature_quantizer: RTL

Input stage of the classifier. It accepts a stream of raw unsigned flow-feature words, one feature per beat. Each word is quantized to a 2-bit code against three per-feature thresholds that software can program. The codes are packed into one record vector, and the completed vector is presented, behind a valid/ready handshake, to the bit-sliced layer-0 neuron LUTs.

---
 rtl/logicnet_pkg.sv | 23 ++
 rtl/feature_threshold_cmp.sv | 19 +
 rtl/flow_feature_quantizer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/logicnet_pkg.sv
// Shared definitions for the classifier input stage: code width, default
// quantizer thresholds, threshold-select encoding of cfg_addr, FSM states.
package logicnet_pkg;

    localparam int unsigned Q_WIDTH   = 2;
    localparam int unsigned SEL_WIDTH = 2;

    // Low bits of cfg_addr pick which of the three thresholds is written.
    localparam logic [SEL_WIDTH-1:0] SEL_T0 = 2'd0;
    localparam logic [SEL_WIDTH-1:0] SEL_T1 = 2'd1;
    localparam logic [SEL_WIDTH-1:0] SEL_T2 = 2'd2;

    typedef enum logic {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } state_t;

    // Default threshold k (1..3) for a w-bit feature: k quarters of full scale.
    function automatic logic [63:0] default_thr(input int unsigned k, input int unsigned w);
        return (64'(k) << w) >> 2;
    endfunction

endpackage

// File: rtl/feature_threshold_cmp.sv
// Quantizes one unsigned feature against three thresholds.
//   x, t0, t1, t2 : feature value and its thresholds (unsigned, W bits)
//   code_c        : number of thresholds that x meets or exceeds (0..3)
module feature_threshold_cmp #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] t0,
    input  logic [W-1:0] t1,
    input  logic [W-1:0] t2,
    output logic [1:0]   code_c
);

    // Thresholds need not be ordered, so each compare contributes independently.
    always_comb begin
        code_c = 2'(x >= t0) + 2'(x >= t1) + 2'(x >= t2);
    end

endmodule

// File: rtl/flow_feature_quantizer.sv
// Classifier input stage: quantizes a stream of raw feature words to 2-bit
// codes, assembles NUM_FEATURES codes into one record and hands the record
// to the layer-0 LUTs through a one-entry valid/ready output register.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : feature beat handshake; in_data raw value, in_last ends record
//   cfg_we/addr/data    : threshold write, cfg_addr = {feature index, select 0..2}
//   out_valid/out_ready : record handshake; out_data feature i at bits [2i+1:2i]
//   err_frame           : one-cycle pulse after a short or long record is seen
module flow_feature_quantizer #(
    parameter int unsigned NUM_FEATURES = 16,
    parameter int unsigned IN_WIDTH     = 16,
    parameter int unsigned Q_WIDTH      = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [IN_WIDTH-1:0]               in_data,
    input  logic                              in_last,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_FEATURES)+1:0]   cfg_addr,
    input  logic [IN_WIDTH-1:0]               cfg_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_FEATURES*Q_WIDTH-1:0]   out_data,
    output logic                              err_frame
);

    import logicnet_pkg::*;

    localparam int unsigned CNT_W  = $clog2(NUM_FEATURES);
    localparam int unsigned DATA_W = NUM_FEATURES * Q_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_FEATURES - 1);

    logic [IN_WIDTH-1:0] thr_q [NUM_FEATURES][3];

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                ov_q, ov_d;
    logic                err_q, err_d;

    logic [1:0]          code_c;
    logic                at_last;
    logic                stall;
    logic                accept;
    logic [CNT_W-1:0]    cfg_idx;
    logic [SEL_WIDTH-1:0] cfg_sel;

    assign cfg_idx = cfg_addr[CNT_W+1:2];
    assign cfg_sel = cfg_addr[1:0];

    // Threshold bank; a write lands after the edge, so a same-cycle beat sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_FEATURES); i++) begin
                for (int j = 0; j < 3; j++) begin
                    thr_q[i][j] <= IN_WIDTH'(default_thr(32'(j + 1), IN_WIDTH));
                end
            end
        end else if (cfg_we && (cfg_sel <= SEL_T2) && (32'(cfg_idx) < NUM_FEATURES)) begin
            thr_q[cfg_idx][cfg_sel] <= cfg_data;
        end
    end

    feature_threshold_cmp #(.W(IN_WIDTH)) u_cmp (
        .x      (in_data),
        .t0     (thr_q[cnt_q][SEL_T0]),
        .t1     (thr_q[cnt_q][SEL_T1]),
        .t2     (thr_q[cnt_q][SEL_T2]),
        .code_c (code_c)
    );

    // Only the record-completing beat needs the output slot, so only it can stall.
    assign at_last  = (cnt_q == LAST_IDX);
    assign stall    = (state_q == COLLECT) && at_last && ov_q && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && !stall;

    // Next-state: framing FSM, slot assembly and output register load/drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        out_d   = out_q;
        ov_d    = ov_q;
        err_d   = 1'b0;

        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                COLLECT: begin
                    asm_d[32'(cnt_q) * Q_WIDTH +: Q_WIDTH] = Q_WIDTH'(code_c);
                    if (in_last) begin
                        cnt_d = '0;
                        if (at_last) begin
                            // Overrides a same-cycle drain: back-to-back records.
                            out_d = asm_d;
                            ov_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (at_last) begin
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DISCARD: begin
                    if (in_last) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            asm_q   <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = out_q;
    assign err_frame = err_q;

endmodule
